// File: rtl/pwm_multi_if.sv
// Control/output bundle between a register block and the multi-channel PWM generator.
interface pwm_multi_if #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
);
  logic                         en;
  logic                         center_mode;
  logic [PRESCALE_WIDTH-1:0]    prescale;
  logic [DATA_WIDTH-1:0]        top;
  logic [NUM_CH*DATA_WIDTH-1:0] compare;
  logic [NUM_CH-1:0]            polarity;
  logic [NUM_CH-1:0]            out;
  logic                         period_start;
  logic [DATA_WIDTH-1:0]        cnt_value;

  modport master (
    output en, center_mode, prescale, top, compare, polarity,
    input  out, period_start, cnt_value
  );

  modport slave (
    input  en, center_mode, prescale, top, compare, polarity,
    output out, period_start, cnt_value
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter (edge or center aligned),
// per-channel compare/polarity, all settings shadowed at period boundaries.
module pwm_multi #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  pwm_multi_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0]     CntOne = DATA_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PreOne = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0]    pre_cnt_q;
  logic [DATA_WIDTH-1:0]        cnt_q, cnt_d;
  logic                         dir_down_q, dir_down_d;
  logic [DATA_WIDTH-1:0]        top_sh_q;
  logic [NUM_CH*DATA_WIDTH-1:0] cmp_sh_q;
  logic [NUM_CH-1:0]            pol_sh_q;
  logic                         center_sh_q;
  logic [NUM_CH-1:0]            out_q;
  logic                         ps_q;
  logic                         tick;
  logic                         boundary;
  logic [NUM_CH-1:0]            act;

  // pre_cnt may sit above a freshly lowered prescale; it then wraps naturally.
  assign tick = (pre_cnt_q == bus.prescale);

  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    boundary   = 1'b0;
    if (tick) begin
      if (!center_sh_q) begin
        if (cnt_q < top_sh_q) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          cnt_d    = '0;
          boundary = 1'b1;
        end
      end else if (!dir_down_q) begin
        if (cnt_q < top_sh_q) begin
          cnt_d      = cnt_q + CntOne;
          dir_down_d = (cnt_d == top_sh_q);
        end else begin
          // Only reachable with top_sh == 0: counter parks at 0, boundary every tick.
          cnt_d    = '0;
          boundary = 1'b1;
        end
      end else begin
        if (cnt_q <= CntOne) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    end
    if (boundary) begin
      dir_down_d = 1'b0;
    end
  end

  always_comb begin
    act = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      act[i] = (cnt_q < cmp_sh_q[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      dir_down_q  <= 1'b0;
      top_sh_q    <= '0;
      cmp_sh_q    <= '0;
      pol_sh_q    <= '0;
      center_sh_q <= 1'b0;
      out_q       <= '0;
      ps_q        <= 1'b0;
    end else if (!bus.en) begin
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      dir_down_q  <= 1'b0;
      top_sh_q    <= bus.top;
      cmp_sh_q    <= bus.compare;
      pol_sh_q    <= bus.polarity;
      center_sh_q <= bus.center_mode;
      out_q       <= pol_sh_q;
      ps_q        <= 1'b0;
    end else begin
      pre_cnt_q  <= tick ? '0 : pre_cnt_q + PreOne;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      out_q      <= act ^ pol_sh_q;
      ps_q       <= boundary;
      if (boundary) begin
        top_sh_q    <= bus.top;
        cmp_sh_q    <= bus.compare;
        pol_sh_q    <= bus.polarity;
        center_sh_q <= bus.center_mode;
      end
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;
  assign bus.cnt_value    = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: waveform patterns per period, shadowing, limits, enable/reset.
module tb_pwm_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_multi_if #(.NUM_CH(2), .DATA_WIDTH(8), .PRESCALE_WIDTH(8)) bus ();

  pwm_multi #(
    .NUM_CH        (2),
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until period_start is seen; reports clocks taken.
  task automatic wait_ps(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.period_start && n < 2000);
    if (!bus.period_start) check_eq(tag, 64'd0, 64'd1);
  endtask

  // Shifts in out[ch] for n clocks (oldest sample ends up most significant).
  task automatic cap(input int n, input int ch, output logic [31:0] pat, output int ps_cnt,
                     output int ones);
    pat    = '0;
    ps_cnt = 0;
    ones   = 0;
    repeat (n) begin
      step();
      pat    = {pat[30:0], bus.out[ch]};
      ps_cnt += int'(bus.period_start);
      ones   += int'(bus.out[ch]);
    end
  endtask

  task automatic go_idle();
    bus.en = 1'b0;
    step();
    step();
  endtask

  logic [31:0] pat;
  int          ps;
  int          ones;
  int          n;

  initial begin
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.center_mode = 1'b0;
    bus.prescale    = 8'd0;
    bus.top         = 8'd9;
    bus.compare     = {8'd0, 8'd3};
    bus.polarity    = 2'b10;
    #12;
    check_eq("rst_out", 64'(bus.out), 64'd0);
    check_eq("rst_ps", 64'(bus.period_start), 64'd0);
    check_eq("rst_cnt", 64'(bus.cnt_value), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check_eq("idle_out", 64'(bus.out), 64'b10);
    bus.polarity = 2'b00;
    go_idle();

    // Edge mode, top=9, cmp ch0=3 ch1=0
    bus.en = 1'b1;
    wait_ps("t1_wait", n);
    check_eq("t1_lat", 64'(n), 64'd10);
    check_eq("t1_cnt0", 64'(bus.cnt_value), 64'd0);
    cap(10, 0, pat, ps, ones);
    check_eq("t1_ch0", 64'(pat), 64'b1110000000);
    check_eq("t1_ps", 64'(ps), 64'd1);
    cap(10, 1, pat, ps, ones);
    check_eq("t1_ch1", 64'(pat), 64'd0);

    // Shadowing: compare change mid-period applies next period
    cap(5, 0, pat, ps, ones);
    check_eq("sh_first", 64'(pat), 64'b11100);
    check_eq("sh_cnt5", 64'(bus.cnt_value), 64'd5);
    bus.compare = {8'd0, 8'd7};
    cap(5, 0, pat, ps, ones);
    check_eq("sh_rest", 64'(pat), 64'b00000);
    check_eq("sh_ps", 64'(ps), 64'd1);
    cap(10, 0, pat, ps, ones);
    check_eq("sh_new", 64'(pat), 64'b1111111000);

    // Edge mode, prescale=3, top=4, cmp=2
    go_idle();
    bus.compare  = {8'd0, 8'd2};
    bus.prescale = 8'd3;
    bus.top      = 8'd4;
    step();
    bus.en = 1'b1;
    wait_ps("t2_wait", n);
    cap(20, 0, pat, ps, ones);
    check_eq("t2_ch0", 64'(pat), 64'b11111111000000000000);
    check_eq("t2_ps", 64'(ps), 64'd1);

    // Center mode, prescale=0, top=4, cmp=2
    go_idle();
    bus.center_mode = 1'b1;
    bus.prescale    = 8'd0;
    step();
    bus.en = 1'b1;
    wait_ps("c_wait", n);
    check_eq("c_cnt0", 64'(bus.cnt_value), 64'd0);
    cap(4, 0, pat, ps, ones);
    check_eq("c_up", 64'(pat), 64'b1100);
    check_eq("c_cnt4", 64'(bus.cnt_value), 64'd4);
    cap(4, 0, pat, ps, ones);
    check_eq("c_down", 64'(pat), 64'b0001);
    check_eq("c_ps", 64'(ps), 64'd1);

    // Limits: cmp=0 and cmp=top+1, then inverted polarity (shadowed)
    go_idle();
    bus.center_mode = 1'b0;
    bus.top         = 8'd9;
    bus.compare     = {8'd10, 8'd0};
    step();
    bus.en = 1'b1;
    wait_ps("l_wait", n);
    cap(10, 0, pat, ps, ones);
    check_eq("l_cmp0", 64'(pat), 64'd0);
    cap(10, 1, pat, ps, ones);
    check_eq("l_cmpfull", 64'(pat), 64'h3ff);
    bus.polarity = 2'b11;
    cap(10, 0, pat, ps, ones);
    check_eq("l_pol_held", 64'(pat), 64'd0);
    cap(10, 0, pat, ps, ones);
    check_eq("l_pol_ch0", 64'(pat), 64'h3ff);
    cap(10, 1, pat, ps, ones);
    check_eq("l_pol_ch1", 64'(pat), 64'd0);

    // top=255, cmp=255: exactly one low tick per period
    go_idle();
    bus.polarity = 2'b00;
    bus.top      = 8'd255;
    bus.compare  = {8'd0, 8'd255};
    step();
    bus.en = 1'b1;
    wait_ps("m_wait", n);
    cap(256, 0, pat, ps, ones);
    check_eq("m_ones", 64'(ones), 64'd255);
    check_eq("m_tail", 64'(pat), 64'hffff_fffe);
    check_eq("m_ps", 64'(ps), 64'd1);

    // Drop enable mid-period, then re-enable
    go_idle();
    bus.top      = 8'd9;
    bus.compare  = {8'd0, 8'd3};
    bus.polarity = 2'b10;
    step();
    bus.en = 1'b1;
    wait_ps("de_wait", n);
    cap(2, 0, pat, ps, ones);
    check_eq("de_pre", 64'(bus.out), 64'b11);
    bus.en = 1'b0;
    step();
    check_eq("de_out", 64'(bus.out), 64'b10);
    check_eq("de_cnt", 64'(bus.cnt_value), 64'd0);
    check_eq("de_ps", 64'(bus.period_start), 64'd0);
    step();
    bus.en = 1'b1;
    wait_ps("re_wait", n);
    check_eq("re_lat", 64'(n), 64'd10);

    // Asynchronous reset mid-period
    cap(3, 0, pat, ps, ones);
    check_eq("ar_pre", 64'(bus.cnt_value), 64'd3);
    rst_n = 1'b0;
    #1;
    check_eq("ar_out", 64'(bus.out), 64'd0);
    check_eq("ar_cnt", 64'(bus.cnt_value), 64'd0);
    check_eq("ar_ps", 64'(bus.period_start), 64'd0);
    bus.en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator with a shared timebase: one prescaler and one period counter drive NUM_CH independent compare channels.
- Adds a programmable period (top) in place of the fixed 2^N period, plus edge- or center-aligned counting.
- Per-channel output polarity; all settings are shadowed and take effect only at period boundaries.
- Sits between a register/control block and pad outputs (motor, LED, servo drive).

Parameters:
- NUM_CH, 4, number of PWM output channels (1..32)
- DATA_WIDTH, 16, width of period counter, top and compare values
- PRESCALE_WIDTH, 8, width of prescale input

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable, synchronous
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned; shadowed
- prescale  input  PRESCALE_WIDTH  tick every prescale+1 clk; not shadowed
- top  input  DATA_WIDTH  period counter terminal value; shadowed
- compare  input  NUM_CH*DATA_WIDTH  channel i compare in bits [i*DATA_WIDTH +: DATA_WIDTH]; shadowed
- polarity  input  NUM_CH  1 = inverted output for channel i; shadowed
- out  output  NUM_CH  PWM outputs, registered
- period_start  output  1  one-clk pulse when shadow registers load at a period boundary
- cnt_value  output  DATA_WIDTH  current period counter value, for debug and sync

Behaviour:
- Reset (rst_n=0, async):
  - pre_cnt, cnt, dir(up) = 0.
  - All shadow registers = 0.
  - out = 0, period_start = 0.
- Idle (en=0, synchronous):
  - pre_cnt, cnt held at 0; dir = up.
  - Shadows load from the inputs every clk.
  - out[i] = shadow polarity[i] (inactive level); period_start = 0.
- Prescaler:
  - When running, pre_cnt increments each clk.
  - When pre_cnt == prescale: tick = 1 and pre_cnt <= 0.
  - prescale = 0 gives a tick every clk.
  - A prescale change applies immediately. If pre_cnt > prescale, pre_cnt continues and wraps through 2^PRESCALE_WIDTH. This is legal and not an error.
- Edge mode, on tick:
  - cnt < top_sh: cnt <= cnt+1.
  - cnt == top_sh: cnt <= 0, boundary = 1.
  - Period = (top_sh+1)*(prescale+1) clk.
- Center mode, on tick:
  - Counts up 0..top_sh, then down to 0. Direction flips on the tick where cnt reaches top_sh (going up) or 0 (going down).
  - boundary = 1 on the tick where cnt goes 1 -> 0 while counting down.
  - Period = 2*top_sh ticks.
  - top_sh = 0: cnt stays 0, boundary every tick.
- Boundary:
  - On the same clk edge, all shadows load: top, compare, polarity, center_mode.
  - dir <= up.
  - period_start = 1 in the following clk only.
  - A center_mode change takes effect only here; the counter restarts from 0.
- Compare, combinational:
  - act[i] = (cnt < cmp_sh[i]).
  - out[i] <= act[i] XOR pol_sh[i], registered: out lags cnt by exactly 1 clk.
- Duty boundaries:
  - cmp_sh == 0: 0% (out = pol constantly).
  - cmp_sh > top_sh: 100% (edge mode; center mode when cmp > top).
  - Edge high time = cmp ticks. Center high time = 2*cmp-1 ticks, symmetric about cnt = 0.
- Enable:
  - On the first clk with en=1 after en=0, the counter starts from 0 using shadows loaded on the last idle clk.
  - Deasserting en mid-period returns to Idle on the next clk edge; the partial period is abandoned.
- Reset mid-operation: all state clears immediately; no period_start is emitted.
- Arithmetic:
  - All compares are unsigned.
  - top = 2^DATA_WIDTH-1 is legal; cnt must not overflow (no wrap beyond top).

Test Plan:
- NUM_CH=2, DATA_WIDTH=8, edge mode, prescale=0, top=9, compare={3,0}, polarity=0, en=1 -> ch0 high 3 clk / low 7 clk repeating; ch1 constantly 0; period_start every 10 clk.
- Edge mode, prescale=3, top=4, cmp=2 -> ch0 high 8 clk / low 12 clk; period 20 clk.
- Shadowing: change compare 3->7 at cnt=5 of a top=9 period -> current period keeps 3-clk high; next period, which starts one clk after the period_start pulse, shows 7-clk high.
- Center mode, prescale=0, top=4, cmp=2 -> cnt sequence 0,1,2,3,4,3,2,1,0,... ; out high for cnt in {0,1}, i.e. 3 clk high / 5 clk low per 8-clk period.
- Limits: cmp=0 -> constant 0; cmp=top+1 -> constant 1; polarity=1 inverts both; top=255, cmp=255 in edge mode -> low exactly 1 tick per period.
- Control: assert rst_n=0 mid-period -> out=0, cnt_value=0 asynchronously. Drop en mid-period -> next clk out=polarity, cnt=0. Reassert en -> period_start appears at the first boundary after restart.
